axi_write_arbiter: RTL and testbench

Two-master to one-slave AXI3 write-channel arbiter used in the BFM testbenches. It lets two `axi_master_bfm` instances share one `axi_slave_generic` write port. It grants the AW/W/B channels to one master per burst and holds that grant until the write response completes. It also checks W beat count against the latched AWLEN and raises a sticky protocol error on a mismatch.

---
 rtl/axi_write_arbiter.sv | 149 ++++++++++++++
 tb/tb_axi_write_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_arbiter.sv
// Two-master to one-slave AXI3 write arbiter: one burst owns AW/W/B until its B handshake.
// Define AXI_ARB_ROUND_ROBIN_EN for round-robin tie-break; otherwise master 0 has fixed priority.
module axi_write_arbiter #(
  parameter  int ID_W   = 4,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 32,
  localparam int AW_W   = ID_W + ADDR_W + 18,
  localparam int W_W    = ID_W + DATA_W + DATA_W/8 + 1,
  localparam int B_W    = ID_W + 2
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [1:0]        m_awvalid,
  output logic [1:0]        m_awready,
  input  logic [2*AW_W-1:0] m_aw,
  input  logic [1:0]        m_wvalid,
  output logic [1:0]        m_wready,
  input  logic [2*W_W-1:0]  m_w,
  output logic [1:0]        m_bvalid,
  input  logic [1:0]        m_bready,
  output logic [B_W-1:0]    m_b,
  output logic              s_awvalid,
  input  logic              s_awready,
  output logic [AW_W-1:0]   s_aw,
  output logic              s_wvalid,
  input  logic              s_wready,
  output logic [W_W-1:0]    s_w,
  input  logic              s_bvalid,
  output logic              s_bready,
  input  logic [B_W-1:0]    s_b,
  output logic [1:0]        grant,
  output logic              protocol_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic [3:0]  len_q, len_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        protocol_err_q, protocol_err_d;

  logic            g;
  logic            win;
  logic [AW_W-1:0] aw_sel;
  logic [W_W-1:0]  w_sel;
  logic            wlast;

  assign g      = grant_q[1];
  assign aw_sel = g ? m_aw[2*AW_W-1:AW_W] : m_aw[AW_W-1:0];
  assign w_sel  = g ? m_w[2*W_W-1:W_W]    : m_w[W_W-1:0];
  assign wlast  = w_sel[0];

  // win is the index of the master granted when leaving IDLE
`ifdef AXI_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (&m_awvalid) win = ~last_grant_q;
    else            win = ~m_awvalid[0];
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
  assign win = ~m_awvalid[0];
`endif

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    len_d          = len_q;
    beat_cnt_d     = beat_cnt_q;
    protocol_err_d = protocol_err_q;
    m_awready      = '0;
    m_wready       = '0;
    m_bvalid       = '0;
    s_awvalid      = 1'b0;
    s_aw           = '0;
    s_wvalid       = 1'b0;
    s_w            = '0;
    s_bready       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|m_awvalid) begin
          grant_d = win ? 2'b10 : 2'b01;
          state_d = ADDR;
        end
      end
      ADDR: begin
        s_awvalid    = m_awvalid[g];
        s_aw         = aw_sel;
        m_awready[g] = s_awready;
        if (m_awvalid[g] && s_awready) begin
          len_d      = aw_sel[17:14];
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        s_wvalid    = m_wvalid[g];
        s_w         = w_sel;
        m_wready[g] = s_wready;
        if (m_wvalid[g] && s_wready) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          // beat_cnt_q holds the number of beats already accepted before this one
          if (wlast) begin
            if (beat_cnt_q != len_q) protocol_err_d = 1'b1;
            state_d = RESP;
          end else if (beat_cnt_q == len_q) begin
            protocol_err_d = 1'b1;
          end
        end
      end
      RESP: begin
        m_bvalid[g] = s_bvalid;
        s_bready    = m_bready[g];
        if (s_bvalid && m_bready[g]) begin
          last_grant_d = g;
          grant_d      = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      last_grant_q   <= 1'b1;
      len_q          <= '0;
      beat_cnt_q     <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      last_grant_q   <= last_grant_d;
      len_q          <= len_d;
      beat_cnt_q     <= beat_cnt_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  assign m_b          = s_b;
  assign grant        = grant_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed self-checking bench for axi_write_arbiter; the bench acts as both masters and the slave.
module tb_axi_write_arbiter;
  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int AW_W   = ID_W + ADDR_W + 18;
  localparam int W_W    = ID_W + DATA_W + DATA_W/8 + 1;
  localparam int B_W    = ID_W + 2;

  logic              aclk, areset;
  logic [1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [2*AW_W-1:0] m_aw;
  logic [2*W_W-1:0]  m_w;
  logic [B_W-1:0]    m_b, s_b;
  logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [AW_W-1:0]   s_aw;
  logic [W_W-1:0]    s_w;
  logic [1:0]        grant;
  logic              protocol_err;

  int checks   = 0;
  int failures = 0;

  axi_write_arbiter #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .aclk(aclk), .areset(areset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_aw(m_aw),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_w(m_w),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_b(m_b),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b),
    .grant(grant), .protocol_err(protocol_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [AW_W-1:0] mk_aw(input int m, input logic [3:0] len);
    return {4'(m + 1), 32'h100 + 32'(m) * 32'h1000, len, 3'd2, 2'd1, 2'd0, 4'd0, 3'd0};
  endfunction

  int burst_no = 0;

  function automatic logic [W_W-1:0] mk_w(input int m, input int b, input bit last);
    return {4'(m + 1), 32'hD000_0000 | (32'(burst_no) << 8) | (32'(m) << 16) | 32'(b), 4'hF, last};
  endfunction

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // One complete burst from master m, which the caller expects to win the next arbitration.
  task automatic burst(input int m, input logic [3:0] len, input int nbeats, input int aw_stall,
                       input bit wtog, input logic [3:0] bid, input bit keep_req, input int rst_after);
    logic [1:0] oh;
    oh = (m == 0) ? 2'b01 : 2'b10;
    burst_no++;
    m_awvalid[m] = 1'b1;
    m_aw[m*AW_W +: AW_W] = mk_aw(m, len);
    settle();
    check_eq("idle_awvalid", 64'(s_awvalid), 64'd0);
    tick();
    check_eq("grant", 64'(grant), 64'(oh));
    check_eq("arb_latency", 64'(s_awvalid), 64'd1);
    check_eq("aw_payload", 64'(s_aw), 64'(mk_aw(m, len)));
    for (int k = 0; k < aw_stall; k++) begin
      check_eq("aw_stall", 64'(m_awready), 64'd0);
      tick();
    end
    s_awready = 1'b1;
    settle();
    check_eq("aw_ready", 64'(m_awready), 64'(oh));
    tick();
    s_awready = 1'b0;
    if (!keep_req) m_awvalid[m] = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      m_wvalid[m] = 1'b1;
      m_w[m*W_W +: W_W] = mk_w(m, b, b == nbeats - 1);
      if (b == rst_after) begin
        areset = 1'b1;
        tick();
        areset = 1'b0;
        settle();
        check_eq("rst_grant", 64'(grant), 64'd0);
        check_eq("rst_valids", 64'({s_awvalid, s_wvalid, m_bvalid}), 64'd0);
        check_eq("rst_readies", 64'({m_awready, m_wready, s_bready}), 64'd0);
        check_eq("rst_err", 64'(protocol_err), 64'd0);
        m_wvalid = '0;
        return;
      end
      if (wtog) begin
        s_wready = 1'b0;
        settle();
        check_eq("w_stall", 64'(m_wready), 64'd0);
        tick();
      end
      s_wready = 1'b1;
      settle();
      check_eq("w_payload", 64'(s_w), 64'(mk_w(m, b, b == nbeats - 1)));
      check_eq("w_ready", 64'(m_wready), 64'(oh));
      tick();
    end
    m_wvalid = '0;
    s_wready = 1'b0;
    s_bvalid = 1'b1;
    s_b      = {bid, 2'b00};
    m_bready = ~oh;
    settle();
    check_eq("b_route", 64'(m_bvalid), 64'(oh));
    check_eq("b_payload", 64'(m_b), 64'({bid, 2'b00}));
    check_eq("b_ignore_other", 64'(s_bready), 64'd0);
    tick();
    m_bready = oh;
    settle();
    check_eq("b_ready", 64'(s_bready), 64'd1);
    tick();
    s_bvalid = 1'b0;
    m_bready = '0;
    settle();
    check_eq("idle_after_b", 64'({grant, s_awvalid}), 64'd0);
  endtask

`ifdef AXI_ARB_ROUND_ROBIN_EN
  int order[6] = '{0, 1, 0, 1, 0, 1};
  bit keep[6]  = '{1, 1, 1, 1, 0, 0};
`else
  int order[6] = '{0, 0, 0, 1, 1, 1};
  bit keep[6]  = '{1, 1, 0, 1, 1, 0};
`endif

  initial begin
    areset = 1'b1;
    m_awvalid = '0; m_aw = '0; m_wvalid = '0; m_w = '0; m_bready = '0;
    s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_b = '0;
    tick();
    tick();
    areset = 1'b0;
    settle();
    check_eq("reset_grant", 64'(grant), 64'd0);
    check_eq("reset_valids", 64'({s_awvalid, s_wvalid, m_bvalid}), 64'd0);
    check_eq("reset_readies", 64'({m_awready, m_wready, s_bready}), 64'd0);
    check_eq("reset_err", 64'(protocol_err), 64'd0);

    // single master 0 burst, then backpressured burst
    burst(0, 4'd3, 4, 0, 1'b0, 4'h0, 1'b0, -1);
    check_eq("single_err", 64'(protocol_err), 64'd0);
    burst(0, 4'd2, 3, 5, 1'b1, 4'h1, 1'b0, -1);
    check_eq("bp_err", 64'(protocol_err), 64'd0);

    // simultaneous requests, three bursts per master
    do_reset();
    m_aw[AW_W-1:0]      = mk_aw(0, 4'd1);
    m_aw[2*AW_W-1:AW_W] = mk_aw(1, 4'd1);
    m_awvalid = 2'b11;
    for (int i = 0; i < 6; i++) burst(order[i], 4'd1, 2, 0, 1'b0, 4'(i), keep[i], -1);
    check_eq("arb_err", 64'(protocol_err), 64'd0);

    // early wlast
    burst(0, 4'd3, 2, 0, 1'b0, 4'h2, 1'b0, -1);
    check_eq("early_wlast_err", 64'(protocol_err), 64'd1);

    // reset mid-DATA, then master 1 burst with B routing
    burst(0, 4'd3, 4, 0, 1'b0, 4'h0, 1'b0, 2);
    tick();
    burst(1, 4'd3, 4, 0, 1'b0, 4'h5, 1'b0, -1);
    check_eq("m1_after_rst_err", 64'(protocol_err), 64'd0);

    // late wlast
    do_reset();
    burst(0, 4'd3, 5, 0, 1'b0, 4'h3, 1'b0, -1);
    check_eq("late_wlast_err", 64'(protocol_err), 64'd1);
    tick();
    check_eq("err_sticky", 64'(protocol_err), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
